// File: rtl/cache_read_data_aligner.sv
// Read-data aligner: extracts, right-justifies and extends a possibly
// line-straddling read from one or two cache-line beats.
module cache_read_data_aligner #(
    parameter int p_line_nbytes = 16,
    parameter int p_idx_nbits   = $clog2(p_line_nbytes)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       req_val,
    output logic                       req_rdy,
    input  logic [3:0]                 req_type,
    input  logic [p_idx_nbits-1:0]     req_len,
    input  logic [p_idx_nbits-1:0]     req_offset,
    input  logic                       req_signed,
    input  logic                       line_val,
    output logic                       line_rdy,
    input  logic [8*p_line_nbytes-1:0] line_data,
    output logic                       resp_val,
    input  logic                       resp_rdy,
    output logic [8*p_line_nbytes-1:0] resp_data,
    output logic                       resp_err
);

    localparam int W  = 8 * p_line_nbytes;
    localparam int NB = p_idx_nbits + 1;
    localparam logic [NB-1:0] LP_LINE = NB'(p_line_nbytes);
    localparam logic [3:0] LP_TYPE_READ = 4'd0;

    typedef enum logic [1:0] {
        IDLE,
        BEAT0,
        BEAT1,
        RESP
    } state_t;

    state_t                 r_state;
    logic [3:0]             r_type;
    logic [p_idx_nbits-1:0] r_len;
    logic [p_idx_nbits-1:0] r_off;
    logic                   r_signed;
    logic [W-1:0]           r_line0;
    logic [W-1:0]           r_data;
    logic                   r_err;

    logic [NB-1:0] w_nbytes;
    logic [NB-1:0] w_nm1;
    logic [NB-1:0] w_end;
    logic          w_read;
    logic          w_legal;
    logic          w_cross;

    assign w_nbytes = (r_len == '0) ? LP_LINE : {1'b0, r_len};
    assign w_nm1    = w_nbytes - NB'(1);
    assign w_end    = {1'b0, r_off} + w_nbytes;
    assign w_read   = (r_type == LP_TYPE_READ);
    assign w_legal  = (w_nbytes & w_nm1) == '0;
    assign w_cross  = w_read & w_legal & (w_end > LP_LINE);

    logic [W-1:0]   w_lo;
    logic [W-1:0]   w_hi;
    logic [2*W-1:0] w_wide;
    logic [W-1:0]   w_s;
    logic [W-1:0]   w_res;
    logic           w_sign;
    logic           w_err;

    // The upper line only contributes in BEAT1; in BEAT0 the window fits line0.
    always_comb begin
        w_lo   = (r_state == BEAT1) ? r_line0 : line_data;
        w_hi   = (r_state == BEAT1) ? line_data : '0;
        w_wide = {w_hi, w_lo} >> {r_off, 3'b000};
        w_s    = w_wide[W-1:0];
        w_sign = 1'b0;
        w_res  = '0;
        w_err  = 1'b0;
        for (int i = 0; i < p_line_nbytes; i++) begin
            if (NB'(i) == w_nm1) begin
                w_sign = r_signed & w_s[8*i+7];
            end
        end
        if (w_read && !w_legal) begin
            w_err = 1'b1;
        end else if (w_read) begin
            for (int i = 0; i < p_line_nbytes; i++) begin
                w_res[8*i +: 8] = (NB'(i) < w_nbytes) ? w_s[8*i +: 8]
                                                      : {8{w_sign}};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_type   <= '0;
            r_len    <= '0;
            r_off    <= '0;
            r_signed <= 1'b0;
            r_line0  <= '0;
            r_data   <= '0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_val) begin
                        r_type   <= req_type;
                        r_len    <= req_len;
                        r_off    <= req_offset;
                        r_signed <= req_signed;
                        r_state  <= BEAT0;
                    end
                end
                BEAT0: begin
                    if (line_val) begin
                        r_line0 <= line_data;
                        if (w_cross) begin
                            r_state <= BEAT1;
                        end else begin
                            r_data  <= w_res;
                            r_err   <= w_err;
                            r_state <= RESP;
                        end
                    end
                end
                BEAT1: begin
                    if (line_val) begin
                        r_data  <= w_res;
                        r_err   <= w_err;
                        r_state <= RESP;
                    end
                end
                RESP: begin
                    if (resp_rdy) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Reset masks every output so nothing handshakes while it is held.
    assign req_rdy   = ~reset & (r_state == IDLE);
    assign line_rdy  = ~reset & ((r_state == BEAT0) | (r_state == BEAT1));
    assign resp_val  = ~reset & (r_state == RESP);
    assign resp_data = reset ? '0 : r_data;
    assign resp_err  = ~reset & r_err;

endmodule

// File: tb/tb_cache_read_data_aligner.sv
// Bench for cache_read_data_aligner: directed vector table, reset corner
// sequence and randomized transactions against a byte-level model.
module tb_cache_read_data_aligner;

    localparam int W = 128;
    localparam logic [W-1:0] L0 = 128'h0F0E0D0C0B0A09080706050403020100;
    localparam logic [W-1:0] L1 = 128'h1F1E1D1C1B1A19181716151413121110;
    localparam logic [W-1:0] L0S = 128'h0F0E0D0C0B0A09080706050480020100;
    localparam logic [W-1:0] L0P = 128'h0F0E0D0C0B0A090807060504127F0100;

    logic         clk = 1'b0;
    logic         reset;
    logic         req_val;
    logic         req_rdy;
    logic [3:0]   req_type;
    logic [3:0]   req_len;
    logic [3:0]   req_offset;
    logic         req_signed;
    logic         line_val;
    logic         line_rdy;
    logic [W-1:0] line_data;
    logic         resp_val;
    logic         resp_rdy;
    logic [W-1:0] resp_data;
    logic         resp_err;

    int n_pass = 0;
    int n_total = 0;

    cache_read_data_aligner #(.p_line_nbytes(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_val    (req_val),
        .req_rdy    (req_rdy),
        .req_type   (req_type),
        .req_len    (req_len),
        .req_offset (req_offset),
        .req_signed (req_signed),
        .line_val   (line_val),
        .line_rdy   (line_rdy),
        .line_data  (line_data),
        .resp_val   (resp_val),
        .resp_rdy   (resp_rdy),
        .resp_data  (resp_data),
        .resp_err   (resp_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string nm, input logic [W-1:0] act,
                         input logic [W-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    function automatic void model(input logic [3:0] t, input logic [3:0] len,
                                  input logic [3:0] off, input logic sgn,
                                  input logic [W-1:0] l0, input logic [W-1:0] l1,
                                  output logic [W-1:0] d, output logic e,
                                  output int beats);
        byte unsigned b[32];
        int nb;
        int o;
        bit neg;
        for (int i = 0; i < 16; i++) begin
            b[i]      = l0[8*i +: 8];
            b[16 + i] = l1[8*i +: 8];
        end
        nb = (len == 0) ? 16 : int'(len);
        o = int'(off);
        d = '0;
        e = 1'b0;
        beats = 1;
        if (t != 4'd0) return;
        if ($countones(nb) != 1) begin
            e = 1'b1;
            return;
        end
        if (o + nb > 16) beats = 2;
        neg = sgn && b[o + nb - 1][7];
        for (int i = 0; i < 16; i++) begin
            if (i < nb) d[8*i +: 8] = b[o + i];
            else if (neg) d[8*i +: 8] = 8'hFF;
        end
    endfunction

    task automatic run_txn(input logic [3:0] t, input logic [3:0] len,
                           input logic [3:0] off, input logic sgn,
                           input logic [W-1:0] l0, input logic [W-1:0] l1,
                           input int gap, input int hold,
                           output logic [W-1:0] d, output logic e,
                           output int beats, output int lat,
                           output bit busy_ok, output bit stable_ok,
                           output bit timed_out);
        bit acc, hsr, hsl, hsp;
        int gapcnt, held;
        acc = 0; hsr = 0; hsl = 0; hsp = 0;
        beats = 0; lat = -1; gapcnt = gap; held = 0;
        busy_ok = 1; stable_ok = 1; timed_out = 1;
        d = '0; e = 1'b0;
        req_type = t; req_len = len; req_offset = off; req_signed = sgn;
        for (int k = 0; k < 80; k++) begin
            @(negedge clk);
            if (hsr) begin
                acc = 1;
                req_val = 1'b0;
            end
            if (hsl) beats++;
            if (hsp) begin
                timed_out = 0;
                break;
            end
            if (k == 0) req_val = 1'b1;
            if (acc && req_rdy) busy_ok = 0;
            if (resp_val) begin
                if (lat < 0) begin
                    lat = k;
                    d = resp_data;
                    e = resp_err;
                end else if (resp_data !== d || resp_err !== e) begin
                    stable_ok = 0;
                end
                resp_rdy = (held >= hold);
                held++;
            end else begin
                resp_rdy = 1'b0;
            end
            if (line_rdy && beats == 1 && gapcnt > 0) begin
                line_val = 1'b0;
                gapcnt--;
            end else if (line_rdy) begin
                line_val = 1'b1;
                line_data = (beats == 0) ? l0 : l1;
            end else begin
                line_val = 1'b0;
            end
            hsr = req_val && req_rdy;
            hsl = line_val && line_rdy;
            hsp = resp_val && resp_rdy;
        end
        req_val = 1'b0;
        line_val = 1'b0;
        resp_rdy = 1'b0;
    endtask

    typedef struct {
        logic [3:0]   t;
        logic [3:0]   len;
        logic [3:0]   off;
        logic         sgn;
        logic [W-1:0] l0;
        logic [W-1:0] l1;
        int           gap;
        int           hold;
        logic [W-1:0] xd;
        logic         xe;
        int           xbeats;
        int           xlat;
    } vec_t;

    vec_t vecs[$];

    initial begin
        logic [W-1:0] d, md;
        logic e, me;
        int beats, lat, mbeats;
        bit busy_ok, stable_ok, tout;

        reset = 1'b1; req_val = 1'b0; req_type = '0; req_len = '0;
        req_offset = '0; req_signed = 1'b0; line_val = 1'b0;
        line_data = '0; resp_rdy = 1'b0;

        vecs.push_back('{4'd0, 4'd4, 4'd4, 1'b0, L0, L1, 0, 0,
                         128'h07060504, 1'b0, 1, 2});
        vecs.push_back('{4'd0, 4'd4, 4'd14, 1'b0, L0, L1, 0, 0,
                         128'h11100F0E, 1'b0, 2, 3});
        vecs.push_back('{4'd0, 4'd1, 4'd3, 1'b1, L0S, L1, 0, 0,
                         {{120{1'b1}}, 8'h80}, 1'b0, 1, 2});
        vecs.push_back('{4'd0, 4'd1, 4'd3, 1'b0, L0S, L1, 0, 0,
                         128'h80, 1'b0, 1, 2});
        vecs.push_back('{4'd0, 4'd2, 4'd2, 1'b1, L0P, L1, 0, 0,
                         128'h127F, 1'b0, 1, 2});
        vecs.push_back('{4'd0, 4'd0, 4'd0, 1'b1, L0, L1, 0, 0,
                         L0, 1'b0, 1, 2});
        vecs.push_back('{4'd0, 4'd0, 4'd8, 1'b0, L0, L1, 0, 0,
                         128'h17161514131211100F0E0D0C0B0A0908, 1'b0, 2, 3});
        vecs.push_back('{4'd1, 4'd4, 4'd14, 1'b0, L0, L1, 0, 0,
                         128'h0, 1'b0, 1, 2});
        vecs.push_back('{4'd0, 4'd3, 4'd0, 1'b0, L0, L1, 0, 0,
                         128'h0, 1'b1, 1, 2});
        vecs.push_back('{4'd0, 4'd4, 4'd4, 1'b0, L0, L1, 0, 3,
                         128'h07060504, 1'b0, 1, 2});
        vecs.push_back('{4'd0, 4'd4, 4'd14, 1'b0, L0, L1, 2, 0,
                         128'h11100F0E, 1'b0, 2, 5});
        vecs.push_back('{4'd0, 4'd8, 4'd12, 1'b1, L0, L1, 0, 0,
                         128'h131211100F0E0D0C, 1'b0, 2, 3});
        vecs.push_back('{4'd0, 4'd1, 4'd15, 1'b0, L0, L1, 0, 0,
                         128'h0F, 1'b0, 1, 2});

        repeat (2) @(negedge clk);
        check("rst_req_rdy", W'(req_rdy), '0);
        check("rst_line_rdy", W'(line_rdy), '0);
        check("rst_resp_val", W'(resp_val), '0);
        check("rst_resp_data", resp_data, '0);
        check("rst_resp_err", W'(resp_err), '0);
        reset = 1'b0;
        @(negedge clk);
        check("idle_req_rdy", W'(req_rdy), W'(1));

        foreach (vecs[i]) begin
            run_txn(vecs[i].t, vecs[i].len, vecs[i].off, vecs[i].sgn,
                    vecs[i].l0, vecs[i].l1, vecs[i].gap, vecs[i].hold,
                    d, e, beats, lat, busy_ok, stable_ok, tout);
            check($sformatf("vec%0d_timeout", i), W'(tout), '0);
            check($sformatf("vec%0d_data", i), d, vecs[i].xd);
            check($sformatf("vec%0d_err", i), W'(e), W'(vecs[i].xe));
            check($sformatf("vec%0d_beats", i), W'(beats), W'(vecs[i].xbeats));
            check($sformatf("vec%0d_latency", i), W'(lat), W'(vecs[i].xlat));
            check($sformatf("vec%0d_busy_rdy", i), W'(busy_ok), W'(1));
            if (vecs[i].hold > 0)
                check($sformatf("vec%0d_stable", i), W'(stable_ok), W'(1));
        end

        // Reset pulse while waiting for the second beat.
        @(negedge clk);
        req_type = 4'd0; req_len = 4'd4; req_offset = 4'd14;
        req_signed = 1'b0; req_val = 1'b1;
        @(negedge clk);
        req_val = 1'b0; line_val = 1'b1; line_data = L0;
        @(negedge clk);
        line_val = 1'b0;
        check("b1_line_rdy", W'(line_rdy), W'(1));
        reset = 1'b1;
        @(negedge clk);
        check("rstb1_resp_val", W'(resp_val), '0);
        check("rstb1_line_rdy", W'(line_rdy), '0);
        check("rstb1_req_rdy", W'(req_rdy), '0);
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_req_rdy", W'(req_rdy), W'(1));
        check("post_rst_line_rdy", W'(line_rdy), '0);
        check("post_rst_resp_val", W'(resp_val), '0);
        run_txn(4'd0, 4'd4, 4'd4, 1'b0, L0, L1, 0, 0,
                d, e, beats, lat, busy_ok, stable_ok, tout);
        check("post_rst_data", d, 128'h07060504);
        check("post_rst_beats", W'(beats), W'(1));

        for (int n = 0; n < 150; n++) begin
            logic [3:0] t, len, off;
            logic sgn;
            logic [W-1:0] l0, l1;
            int r, gap, hold;
            r = int'($urandom_range(0, 7));
            t = (r < 5) ? 4'd0 : 4'(r - 4);
            len = 4'($urandom_range(0, 15));
            off = 4'($urandom_range(0, 15));
            sgn = 1'($urandom_range(0, 1));
            l0 = {$urandom, $urandom, $urandom, $urandom};
            l1 = {$urandom, $urandom, $urandom, $urandom};
            gap = int'($urandom_range(0, 2));
            hold = int'($urandom_range(0, 2));
            model(t, len, off, sgn, l0, l1, md, me, mbeats);
            run_txn(t, len, off, sgn, l0, l1, gap, hold,
                    d, e, beats, lat, busy_ok, stable_ok, tout);
            check($sformatf("rnd%0d_data", n), d, md);
            check($sformatf("rnd%0d_err", n), W'(e), W'(me));
            check($sformatf("rnd%0d_beats", n), W'(beats), W'(mbeats));
            if (gap == 0)
                check($sformatf("rnd%0d_latency", n), W'(lat), W'(mbeats + 1));
            if (tout || !busy_ok || !stable_ok)
                check($sformatf("rnd%0d_protocol", n),
                      W'({tout, busy_ok, stable_ok}), W'(3'b011));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
